timer_sched: RTL and testbench

Multi-channel timer scheduler that shares one prescaled base tick among NCH independent software-style timers. Each channel has a reload value and a one-shot/periodic mode. Expirations are queued as pending flags and delivered one at a time over a valid/ready event port, using a round-robin arbiter. It sits between the free-running tick generator logic and the consumers (LED blinkers, sampling strobes) that today each instantiate their own counter.

---
 rtl/timer_sched.sv | 207 ++++++++++++++++++++
 tb/tb_timer_sched.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_sched.sv
// timer_sched: NCH down-counting timers on one shared prescaled tick; expiries are delivered
// one at a time over a round-robin valid/ready event port. Optional: TIMER_SCHED_OVERRUN_EN.
module timer_sched #(
    parameter  int NCH      = 4,
    parameter  int PRESCALE = 12000,
    parameter  int CW       = 16,
    localparam int CHW      = $clog2(NCH)
) (
    input  logic             clki,
    input  logic             rstn,
    input  logic             cfg_we,
    input  logic [CHW-1:0]   cfg_ch,
    input  logic [CW-1:0]    cfg_reload,
    input  logic             cfg_periodic,
    input  logic [NCH-1:0]   start,
    input  logic [NCH-1:0]   stop,
    output logic             base_tick,
    output logic [NCH-1:0]   busy,
    output logic             evt_valid,
    output logic [CHW-1:0]   evt_ch,
    input  logic             evt_ready,
`ifdef TIMER_SCHED_OVERRUN_EN
    output logic [NCH-1:0]   overrun,
    input  logic [NCH-1:0]   overrun_clr,
`endif
    output logic             dbg_arb_present
);

    localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

    typedef enum logic {ARB_IDLE = 1'b0, ARB_PRESENT = 1'b1} arb_state_t;

    logic [PW-1:0]  presc_q, presc_d;
    logic           tick_q, tick_d;

    logic [CW-1:0]  count_q  [NCH];
    logic [CW-1:0]  count_d  [NCH];
    logic [CW-1:0]  reload_q [NCH];
    logic [CW-1:0]  reload_d [NCH];
    logic [CW-1:0]  ld_val   [NCH];
    logic [NCH-1:0] per_q, per_d;
    logic [NCH-1:0] busy_q, busy_d;
    logic [NCH-1:0] pend_q, pend_d;
    logic [NCH-1:0] cfg_sel;
    logic [NCH-1:0] expire;

    arb_state_t     state_q, state_d;
    logic           valid_q, valid_d;
    logic [CHW-1:0] ch_q, ch_d;
    logic [CHW-1:0] rr_q, rr_d;
    logic           hs;
    logic           grant_found;
    logic [CHW-1:0] grant_ch;

    function automatic logic [CHW-1:0] wrap_add(input logic [CHW-1:0] a, input int k);
        return CHW'((int'(a) + k) % NCH);
    endfunction

    always_comb begin
        presc_d = (presc_q == PW'(PRESCALE - 1)) ? '0 : presc_q + PW'(1);
        tick_d  = (presc_q == PW'(PRESCALE - 1));
    end

    // A start that coincides with a config write to the same channel loads the new value.
    always_comb begin
        cfg_sel = '0;
        for (int i = 0; i < NCH; i++) begin
            cfg_sel[i] = cfg_we && (cfg_ch == CHW'(i));
            ld_val[i]  = cfg_sel[i] ? cfg_reload : reload_q[i];
        end
    end

    always_comb begin
        count_d  = count_q;
        reload_d = reload_q;
        per_d    = per_q;
        busy_d   = busy_q;
        expire   = '0;
        for (int i = 0; i < NCH; i++) begin
            if (cfg_sel[i]) begin
                reload_d[i] = cfg_reload;
                per_d[i]    = cfg_periodic;
            end
            if (stop[i]) begin
                busy_d[i] = 1'b0;
            end else if (start[i] && (ld_val[i] != '0)) begin
                count_d[i] = ld_val[i];
                busy_d[i]  = 1'b1;
            end else if (tick_q && busy_q[i]) begin
                if (count_q[i] == CW'(1)) begin
                    expire[i] = 1'b1;
                    if (per_q[i] && (reload_q[i] != '0)) begin
                        count_d[i] = reload_q[i];
                    end else begin
                        count_d[i] = '0;
                        busy_d[i]  = 1'b0;
                    end
                end else begin
                    count_d[i] = count_q[i] - CW'(1);
                end
            end
        end
    end

    // Event port: evt_valid/evt_ch stay frozen from assertion until the edge where
    // evt_valid && evt_ready; exactly one event transfers on that edge.
    assign hs = valid_q && evt_ready;

    always_comb begin
        pend_d = '0;
        for (int i = 0; i < NCH; i++) begin
            pend_d[i] = expire[i] | (pend_q[i] & ~(hs && (ch_q == CHW'(i))));
        end
    end

    always_comb begin
        grant_found = 1'b0;
        grant_ch    = '0;
        for (int k = 0; k < NCH; k++) begin
            if (!grant_found && pend_q[wrap_add(rr_q, k)]) begin
                grant_found = 1'b1;
                grant_ch    = wrap_add(rr_q, k);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        ch_d    = ch_q;
        rr_d    = rr_q;
        case (state_q)
            ARB_IDLE: begin
                if (grant_found) begin
                    ch_d    = grant_ch;
                    valid_d = 1'b1;
                    state_d = ARB_PRESENT;
                end
            end
            ARB_PRESENT: begin
                if (evt_ready) begin
                    valid_d = 1'b0;
                    rr_d    = wrap_add(ch_q, 1);
                    state_d = ARB_IDLE;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clki or negedge rstn) begin
        if (!rstn) begin
            presc_q <= '0;
            tick_q  <= 1'b0;
            per_q   <= '0;
            busy_q  <= '0;
            pend_q  <= '0;
            state_q <= ARB_IDLE;
            valid_q <= 1'b0;
            ch_q    <= '0;
            rr_q    <= '0;
            for (int i = 0; i < NCH; i++) begin
                count_q[i]  <= '0;
                reload_q[i] <= '0;
            end
        end else begin
            presc_q  <= presc_d;
            tick_q   <= tick_d;
            per_q    <= per_d;
            busy_q   <= busy_d;
            pend_q   <= pend_d;
            state_q  <= state_d;
            valid_q  <= valid_d;
            ch_q     <= ch_d;
            rr_q     <= rr_d;
            count_q  <= count_d;
            reload_q <= reload_d;
        end
    end

`ifdef TIMER_SCHED_OVERRUN_EN
    logic [NCH-1:0] ovr_q, ovr_d;

    // A merged expiry (channel already pending) sets the flag; set beats a same-cycle clear.
    assign ovr_d = (ovr_q & ~overrun_clr) | (expire & pend_q);

    always_ff @(posedge clki or negedge rstn) begin
        if (!rstn) begin
            ovr_q <= '0;
        end else begin
            ovr_q <= ovr_d;
        end
    end

    assign overrun = ovr_q;
`endif

    assign base_tick       = tick_q;
    assign busy            = busy_q;
    assign evt_valid       = valid_q;
    assign evt_ch          = ch_q;
    assign dbg_arb_present = (state_q == ARB_PRESENT);

endmodule

// File: tb/tb_timer_sched.sv
// Randomised scoreboard bench for timer_sched: a deadline-based reference model predicts
// every grant, and a negedge monitor checks the live outputs and each accepted event.
module tb_timer_sched;

    localparam int NCH = 4;
    localparam int PRE = 4;
    localparam int CW  = 8;
    localparam int CHW = 2;

    logic           clki;
    logic           rstn;
    logic           cfg_we;
    logic [CHW-1:0] cfg_ch;
    logic [CW-1:0]  cfg_reload;
    logic           cfg_periodic;
    logic [NCH-1:0] start;
    logic [NCH-1:0] stop;
    logic           base_tick;
    logic [NCH-1:0] busy;
    logic           evt_valid;
    logic [CHW-1:0] evt_ch;
    logic           evt_ready;
    logic [NCH-1:0] overrun;
    logic [NCH-1:0] overrun_clr;
    logic           dbg_arb_present;

    timer_sched #(.NCH(NCH), .PRESCALE(PRE), .CW(CW)) dut (
        .clki            (clki),
        .rstn            (rstn),
        .cfg_we          (cfg_we),
        .cfg_ch          (cfg_ch),
        .cfg_reload      (cfg_reload),
        .cfg_periodic    (cfg_periodic),
        .start           (start),
        .stop            (stop),
        .base_tick       (base_tick),
        .busy            (busy),
        .evt_valid       (evt_valid),
        .evt_ch          (evt_ch),
        .evt_ready       (evt_ready),
`ifdef TIMER_SCHED_OVERRUN_EN
        .overrun         (overrun),
        .overrun_clr     (overrun_clr),
`endif
        .dbg_arb_present (dbg_arb_present)
    );

`ifndef TIMER_SCHED_OVERRUN_EN
    assign overrun = '0;
`endif

    // ---------------- clock ----------------
    initial begin
        clki = 1'b0;
        forever #5 clki = ~clki;
    end

    // ---------------- scoreboard state ----------------
    int             n_checks = 0;
    int             n_fail   = 0;
    logic [CHW-1:0] exp_q[$];
    int             hs_cnt[NCH] = '{default: 0};

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Channels are tracked as absolute deadlines on a running base-tick count T.
    int             m_cyc, m_t, m_rr, m_pres;
    logic [NCH-1:0] m_run, m_pend, m_per, m_ovr;
    int             m_rl[NCH];
    int             m_dl[NCH];

    always @(posedge clki or negedge rstn) begin : ref_model
        int             cyc, t, rr, pres, g, rl_old;
        logic           tk, hs, found, per_old;
        logic [NCH-1:0] run, pend, per, ovr, expd, old_pend;
        int             rl[NCH];
        int             dl[NCH];
        if (!rstn) begin
            m_cyc  <= 0;
            m_t    <= 0;
            m_rr   <= 0;
            m_pres <= -1;
            m_run  <= '0;
            m_pend <= '0;
            m_per  <= '0;
            m_ovr  <= '0;
            m_rl   <= '{default: 0};
            m_dl   <= '{default: 0};
            exp_q.delete();
        end else begin
            cyc = m_cyc; t = m_t; rr = m_rr; pres = m_pres;
            run = m_run; pend = m_pend; per = m_per; ovr = m_ovr;
            rl = m_rl; dl = m_dl;
            tk = (cyc >= PRE) && (cyc % PRE == 0);
            if (tk) t++;
            cyc++;
            expd = '0;
            for (int i = 0; i < NCH; i++) begin
                rl_old  = rl[i];
                per_old = per[i];
                if (cfg_we && (int'(cfg_ch) == i)) begin
                    rl[i]  = int'(cfg_reload);
                    per[i] = cfg_periodic;
                end
                if (stop[i]) begin
                    run[i] = 1'b0;
                end else if (start[i] && rl[i] != 0) begin
                    run[i] = 1'b1;
                    dl[i]  = t + rl[i];
                end else if (run[i] && tk && t == dl[i]) begin
                    expd[i] = 1'b1;
                    if (per_old && rl_old != 0) dl[i] = t + rl_old;
                    else run[i] = 1'b0;
                end
            end
            hs = (pres >= 0) && evt_ready;
            for (int i = 0; i < NCH; i++) begin
                if (expd[i] && pend[i]) ovr[i] = 1'b1;
                else if (overrun_clr[i]) ovr[i] = 1'b0;
            end
            old_pend = pend;
            for (int i = 0; i < NCH; i++) begin
                pend[i] = expd[i] | (pend[i] & !(hs && pres == i));
            end
            if (hs) begin
                rr   = (pres + 1) % NCH;
                pres = -1;
            end else if (pres < 0 && old_pend != '0) begin
                found = 1'b0;
                for (int k = 0; k < NCH; k++) begin
                    g = (rr + k) % NCH;
                    if (!found && old_pend[g]) begin
                        found = 1'b1;
                        pres  = g;
                    end
                end
                exp_q.push_back(CHW'(pres));
            end
            m_cyc <= cyc; m_t <= t; m_rr <= rr; m_pres <= pres;
            m_run <= run; m_pend <= pend; m_per <= per; m_ovr <= ovr;
            m_rl <= rl; m_dl <= dl;
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clki) begin
        if (rstn) begin
            chk("base_tick", int'(base_tick), int'((m_cyc >= PRE) && (m_cyc % PRE == 0)));
            chk("busy", int'(busy), int'(m_run));
            chk("evt_valid", int'(evt_valid), int'(m_pres >= 0));
            if (m_pres >= 0) chk("evt_ch", int'(evt_ch), m_pres);
`ifdef TIMER_SCHED_OVERRUN_EN
            chk("overrun", int'(overrun), int'(m_ovr));
`endif
            if (evt_valid && evt_ready) begin
                if (exp_q.size() == 0) chk("evt_unexpected", 1, 0);
                else chk("evt_order", int'(evt_ch), int'(exp_q.pop_front()));
                hs_cnt[evt_ch]++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clki);
            #1;
        end
    endtask

    task automatic do_cfg(input int ch, input int rl, input logic per);
        cfg_we       = 1'b1;
        cfg_ch       = CHW'(ch);
        cfg_reload   = CW'(rl);
        cfg_periodic = per;
        step();
        cfg_we = 1'b0;
    endtask

    task automatic do_start(input logic [NCH-1:0] m);
        start = m;
        step();
        start = '0;
    endtask

    task automatic do_stop(input logic [NCH-1:0] m);
        stop = m;
        step();
        stop = '0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_base_tick"}, int'(base_tick), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_evt_valid"}, int'(evt_valid), 0);
        chk({tag, "_evt_ch"}, int'(evt_ch), 0);
        chk({tag, "_overrun"}, int'(overrun), 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int base;
        int waited;
        rstn = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_reload = '0; cfg_periodic = 1'b0;
        start = '0; stop = '0; evt_ready = 1'b0; overrun_clr = '0;
        #1;
        chk_reset_outputs("por");
        step(3);
        rstn = 1'b1;

        // Idle: ticks only, no events.
        step(100);

        // One-shot ch1, reload 3.
        evt_ready = 1'b1;
        do_cfg(1, 3, 1'b0);
        do_start(4'b0010);
        step(60);

        // Periodic ch0, reload 2; stop after its third accepted event.
        base = hs_cnt[0];
        do_cfg(0, 2, 1'b1);
        do_start(4'b0001);
        waited = 0;
        while (hs_cnt[0] < base + 3 && waited < 100) begin
            step();
            waited++;
        end
        chk("ch0_three_events_in_time", int'(hs_cnt[0] >= base + 3), 1);
        do_stop(4'b0001);
        step(40);

        // All channels reload 1 periodic, started together.
        for (int c = 0; c < NCH; c++) do_cfg(c, 1, 1'b1);
        do_start(4'hF);
        step(40);
        do_stop(4'hF);
        step(20);

        // Back-pressure on ch2.
        evt_ready = 1'b0;
        do_cfg(2, 1, 1'b1);
        do_start(4'b0100);
        step(20);
        chk("hold_valid", int'(evt_valid), 1);
        chk("hold_ch", int'(evt_ch), 2);
`ifdef TIMER_SCHED_OVERRUN_EN
        chk("overrun2_set", int'(overrun[2]), 1);
`endif
        evt_ready = 1'b1;
        step();
        evt_ready = 1'b0;
        step(6);
        overrun_clr = 4'b0100;
        step();
        overrun_clr = '0;
        do_stop(4'b0100);
        evt_ready = 1'b1;
        step(20);

        // Random traffic.
        for (int c = 0; c < 400; c++) begin
            cfg_we       = ($urandom_range(0, 9) == 0);
            cfg_ch       = CHW'($urandom_range(0, NCH - 1));
            cfg_reload   = CW'($urandom_range(0, 5));
            cfg_periodic = 1'($urandom_range(0, 1));
            for (int i = 0; i < NCH; i++) begin
                start[i]       = ($urandom_range(0, 15) == 0);
                stop[i]        = ($urandom_range(0, 31) == 0);
                overrun_clr[i] = ($urandom_range(0, 15) == 0);
            end
            evt_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        cfg_we = 1'b0; start = '0; stop = '0; overrun_clr = '0;

        // Drain every outstanding event.
        do_stop(4'hF);
        evt_ready = 1'b1;
        step(30);
        chk("queue_drained", exp_q.size(), 0);

        // Reset while an event is presented and counts are mid-flight.
        for (int c = 0; c < NCH; c++) do_cfg(c, 2, 1'b1);
        evt_ready = 1'b0;
        do_start(4'hF);
        waited = 0;
        while (!evt_valid && waited < 100) begin
            step();
            waited++;
        end
        chk("valid_before_reset", int'(evt_valid), 1);
        rstn = 1'b0;
        #1;
        chk_reset_outputs("async");
        step(2);
        rstn = 1'b1;
        do_cfg(3, 0, 1'b1);
        do_start(4'b1000);
        step(10);
        chk("busy3_reload0", int'(busy[3]), 0);
        step(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
